// File: rtl/systolic_array_os_stream.sv
`default_nettype none
// systolic_array_os_stream: output-stationary ROWSxCOLS GEMM tile with input skew, K counting, flush and row drain.
// Optional macro SA_SATURATE_EN: accumulators saturate per step instead of wrapping.  Rev 1.0
module systolic_array_os_stream #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 256,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [KW-1:0]               k_len_i,
  input  logic                        a_valid_i,
  output logic                        a_ready_o,
  input  logic [ROWS-1:0][DATA_W-1:0] a_data_i,
  input  logic [COLS-1:0][DATA_W-1:0] b_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [COLS-1:0][ACC_W-1:0]  out_data_o,
  output logic [RW-1:0]               out_row_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int FW         = $clog2(ROWS + COLS);
  localparam int FLUSH_LAST = ROWS + COLS - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          w_clear;
  logic          w_inj_v;

  logic signed [DATA_W-1:0] a_inj [ROWS];
  logic signed [DATA_W-1:0] b_inj [COLS];
  logic signed [DATA_W-1:0] sa_q  [ROWS][ROWS];
  logic                     sav_q [ROWS][ROWS];
  logic signed [DATA_W-1:0] sb_q  [COLS][COLS];
  logic                     sbv_q [COLS][COLS];
  logic signed [DATA_W-1:0] pa_q  [ROWS][COLS];
  logic                     pav_q [ROWS][COLS];
  logic signed [DATA_W-1:0] pb_q  [ROWS][COLS];
  logic                     pbv_q [ROWS][COLS];
  logic signed [DATA_W-1:0] w_a   [ROWS][COLS];
  logic                     w_av  [ROWS][COLS];
  logic signed [DATA_W-1:0] w_b   [ROWS][COLS];
  logic                     w_bv  [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc_q [ROWS][COLS];

  function automatic logic signed [ACC_W-1:0] f_mac(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] prod;
`ifdef SA_SATURATE_EN
    logic signed [ACC_W:0] sum;
    prod = a * b;
    sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    // One guard bit is enough: a single step can overflow by at most one range
    if (sum[ACC_W] != sum[ACC_W-1])
      f_mac = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      f_mac = sum[ACC_W-1:0];
`else
    prod  = a * b;
    f_mac = acc + ACC_W'(prod);
`endif
  endfunction

  assign w_inj_v     = a_valid_i && (state_q == S_LOAD);
  assign a_ready_o   = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_DRAIN);
  assign busy_o      = (state_q != S_IDLE);
  assign out_row_o   = row_q;
  assign done_o      = (state_q == S_DRAIN) && out_ready_i && (row_q == RW'(ROWS - 1));

  always_comb begin
    for (int r = 0; r < ROWS; r++) a_inj[r] = w_inj_v ? $signed(a_data_i[r]) : '0;
    for (int c = 0; c < COLS; c++) b_inj[c] = w_inj_v ? $signed(b_data_i[c]) : '0;
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) out_data_o[c] = acc_q[row_q][c];
  end

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    w_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_len_d = k_len_i;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          w_clear = 1'b1;
          state_d = (k_len_i == '0) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_inj_v) begin
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == k_len_q) begin
            flush_d = '0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == FW'(FLUSH_LAST)) begin
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready_i) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand routing: column 0 / row 0 take the skewed inputs, the rest take the neighbour's registers
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c > 0) begin : g_a_mesh
        assign w_a[r][c]  = pa_q[r][c-1];
        assign w_av[r][c] = pav_q[r][c-1];
      end else if (r > 0) begin : g_a_skew
        assign w_a[r][c]  = sa_q[r][r-1];
        assign w_av[r][c] = sav_q[r][r-1];
      end else begin : g_a_direct
        assign w_a[r][c]  = a_inj[0];
        assign w_av[r][c] = w_inj_v;
      end
      if (r > 0) begin : g_b_mesh
        assign w_b[r][c]  = pb_q[r-1][c];
        assign w_bv[r][c] = pbv_q[r-1][c];
      end else if (c > 0) begin : g_b_skew
        assign w_b[r][c]  = sb_q[c][c-1];
        assign w_bv[r][c] = sbv_q[c][c-1];
      end else begin : g_b_direct
        assign w_b[r][c]  = b_inj[0];
        assign w_bv[r][c] = w_inj_v;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int j = 0; j < ROWS; j++) begin
          sa_q[r][j]  <= '0;
          sav_q[r][j] <= 1'b0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        for (int j = 0; j < COLS; j++) begin
          sb_q[c][j]  <= '0;
          sbv_q[c][j] <= 1'b0;
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          pa_q[r][c]  <= '0;
          pav_q[r][c] <= 1'b0;
          pb_q[r][c]  <= '0;
          pbv_q[r][c] <= 1'b0;
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      for (int r = 0; r < ROWS; r++) begin
        sa_q[r][0]  <= a_inj[r];
        sav_q[r][0] <= w_inj_v;
        for (int j = 1; j < ROWS; j++) begin
          sa_q[r][j]  <= sa_q[r][j-1];
          sav_q[r][j] <= sav_q[r][j-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        sb_q[c][0]  <= b_inj[c];
        sbv_q[c][0] <= w_inj_v;
        for (int j = 1; j < COLS; j++) begin
          sb_q[c][j]  <= sb_q[c][j-1];
          sbv_q[c][j] <= sbv_q[c][j-1];
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          pa_q[r][c]  <= w_a[r][c];
          pav_q[r][c] <= w_av[r][c];
          pb_q[r][c]  <= w_b[r][c];
          pbv_q[r][c] <= w_bv[r][c];
          if (w_clear)
            acc_q[r][c] <= '0;
          else if (w_av[r][c] && w_bv[r][c])
            acc_q[r][c] <= f_mac(acc_q[r][c], w_a[r][c], w_b[r][c]);
        end
      end
    end
  end

endmodule
`default_nettype wire
